// File: rtl/pmod_cls_spi_responder_pkg.sv
// Shared types and constants for the PMOD CLS SPI responder.
package pmod_cls_spi_responder_pkg;

    // One display line, element [c] holds the character at column c
    typedef logic [15:0][7:0] t_pmod_cls_ascii_line_16;

    typedef enum logic [1:0] {
        ST_TEXT,
        ST_ESC,
        ST_PARAM
    } t_cls_resp_state;

    localparam logic [7:0] c_ascii_esc   = 8'h1B;
    localparam logic [7:0] c_ascii_lbrk  = 8'h5B;
    localparam logic [7:0] c_ascii_semi  = 8'h3B;
    localparam logic [7:0] c_ascii_j     = 8'h6A;
    localparam logic [7:0] c_ascii_h     = 8'h48;
    localparam logic [7:0] c_ascii_space = 8'h20;

    // Accumulate one decimal digit into an escape parameter, clamping at max_val
    function automatic logic [6:0] f_sat_param(input logic [6:0] p,
                                               input logic [3:0] d,
                                               input logic [6:0] max_val);
        logic [10:0] acc;
        acc = 11'(p) * 11'd10 + 11'(d);
        return (acc > 11'(max_val)) ? max_val : acc[6:0];
    endfunction

endpackage

// File: rtl/pmod_cls_spi_responder_if.sv
// SPI pin bundle between the CLS driver (master) and the responder (slave).
interface pmod_cls_spi_responder_if;
    logic ei_sck;
    logic ei_csn;
    logic ei_copi;
    logic eo_cipo_o;
    logic eo_cipo_t;

    modport master (output ei_sck, ei_csn, ei_copi, input eo_cipo_o, eo_cipo_t);
    modport slave  (input ei_sck, ei_csn, ei_copi, output eo_cipo_o, eo_cipo_t);
endinterface

// File: rtl/pmod_spi_periph_shifter.sv
// SPI mode-0 receive shifter: input synchronizers, SCK edge detect,
// bit counter, byte strobe and framing-error detection.
module pmod_spi_periph_shifter #(
    parameter int parm_sync_stages = 2
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rstn_20mhz,
    input  logic       sck,
    input  logic       csn,
    input  logic       copi,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       csn_end,
    output logic       err_frame
);

    logic [parm_sync_stages-1:0] sck_sync;
    logic [parm_sync_stages-1:0] csn_sync;
    logic [parm_sync_stages-1:0] copi_sync;
    logic       sck_prev;
    logic       csn_prev;
    logic [2:0] bit_cnt;
    logic [2:0] cnt_next;
    logic [7:0] shift_reg;
    logic       byte_done;
    logic       done_next;
    logic       csn_rise_d;
    logic       frame_pend;
    logic       frame_next;
    logic       sck_s;
    logic       csn_s;
    logic       copi_s;
    logic       sample_en;
    logic       csn_rise;

    assign sck_s    = sck_sync[parm_sync_stages-1];
    assign csn_s    = csn_sync[parm_sync_stages-1];
    assign copi_s   = copi_sync[parm_sync_stages-1];
    assign csn_rise = csn_s & ~csn_prev;
    // A bit landing on the same cycle CSN rises still counts, so the byte completes first
    assign sample_en = sck_s & ~sck_prev & (~csn_s | ~csn_prev);

    // Bring the asynchronous pins into the clock domain; CSN idles high out of reset
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            copi_sync <= '0;
            sck_prev  <= 1'b0;
            csn_prev  <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[parm_sync_stages-2:0], sck};
            csn_sync  <= {csn_sync[parm_sync_stages-2:0], csn};
            copi_sync <= {copi_sync[parm_sync_stages-2:0], copi};
            sck_prev  <= sck_s;
            csn_prev  <= csn_s;
        end
    end

    // Next bit count, byte completion and partial-byte detection at end of frame
    always_comb begin
        cnt_next   = bit_cnt;
        done_next  = 1'b0;
        frame_next = 1'b0;
        if (sample_en) begin
            cnt_next  = bit_cnt + 3'd1;
            done_next = (bit_cnt == 3'd7);
        end
        if (csn_rise) begin
            frame_next = (cnt_next != 3'd0);
            cnt_next   = 3'd0;
        end
    end

    // Shift in sampled bits and latch the per-bit events for the output stage
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_done  <= 1'b0;
            csn_rise_d <= 1'b0;
            frame_pend <= 1'b0;
        end else begin
            if (sample_en) begin
                shift_reg <= {shift_reg[6:0], copi_s};
            end
            bit_cnt    <= cnt_next;
            byte_done  <= done_next;
            csn_rise_d <= csn_rise;
            frame_pend <= frame_next;
        end
    end

    // Present the completed byte with its strobe; CSN end stays aligned behind it
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            csn_end    <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            byte_valid <= byte_done;
            if (byte_done) begin
                byte_data <= shift_reg;
            end
            csn_end   <= csn_rise_d;
            err_frame <= frame_pend;
        end
    end

endmodule

// File: rtl/pmod_cls_spi_responder.sv
// PMOD CLS peripheral model: receives the SPI byte stream and decodes text
// and ESC[ commands into two 16-character line buffers plus event strobes.
module pmod_cls_spi_responder
    import pmod_cls_spi_responder_pkg::*;
#(
    parameter int parm_sync_stages = 2,
    parameter int parm_line_len    = 16,
    parameter int parm_max_param   = 99
) (
    input  logic                     i_clk_20mhz,
    input  logic                     i_rstn_20mhz,
    pmod_cls_spi_responder_if.slave  spi,
    output logic                     o_byte_valid,
    output logic [7:0]               o_byte_data,
    output logic                     o_evt_clear_display,
    output logic                     o_evt_cursor_set,
    output logic                     o_cursor_row,
    output logic [3:0]               o_cursor_col,
    output t_pmod_cls_ascii_line_16  o_dat_ascii_line1,
    output t_pmod_cls_ascii_line_16  o_dat_ascii_line2,
    output logic                     o_err_frame,
    output logic                     o_err_seq
);

    localparam logic [3:0] c_last_col = 4'(parm_line_len - 1);
    localparam logic [6:0] c_max_par  = 7'(parm_max_param);

    t_cls_resp_state state;
    logic [6:0]      p0;
    logic [6:0]      p1;
    logic            p_sel;
    logic            overflow;
    logic            csn_end;

    // The CLS is write-only, CIPO is never driven
    assign spi.eo_cipo_o = 1'b0;
    assign spi.eo_cipo_t = 1'b1;

    pmod_spi_periph_shifter #(
        .parm_sync_stages (parm_sync_stages)
    ) u_shifter (
        .i_clk_20mhz  (i_clk_20mhz),
        .i_rstn_20mhz (i_rstn_20mhz),
        .sck          (spi.ei_sck),
        .csn          (spi.ei_csn),
        .copi         (spi.ei_copi),
        .byte_valid   (o_byte_valid),
        .byte_data    (o_byte_data),
        .csn_end      (csn_end),
        .err_frame    (o_err_frame)
    );

    // Decode one byte per strobe; end of frame then drops any partial escape
    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state               <= ST_TEXT;
            p0                  <= 7'd0;
            p1                  <= 7'd0;
            p_sel               <= 1'b0;
            overflow            <= 1'b0;
            o_cursor_row        <= 1'b0;
            o_cursor_col        <= 4'd0;
            o_dat_ascii_line1   <= {16{c_ascii_space}};
            o_dat_ascii_line2   <= {16{c_ascii_space}};
            o_evt_clear_display <= 1'b0;
            o_evt_cursor_set    <= 1'b0;
            o_err_seq           <= 1'b0;
        end else begin
            o_evt_clear_display <= 1'b0;
            o_evt_cursor_set    <= 1'b0;
            o_err_seq           <= 1'b0;
            if (o_byte_valid) begin
                case (state)
                    ST_TEXT: begin
                        if (o_byte_data == c_ascii_esc) begin
                            state <= ST_ESC;
                        end else if (o_byte_data >= 8'h20 && o_byte_data <= 8'h7E) begin
                            if (overflow) begin
                                o_err_seq <= 1'b1;
                            end else begin
                                if (o_cursor_row) begin
                                    o_dat_ascii_line2[o_cursor_col] <= o_byte_data;
                                end else begin
                                    o_dat_ascii_line1[o_cursor_col] <= o_byte_data;
                                end
                                if (o_cursor_col == c_last_col) begin
                                    overflow <= 1'b1;
                                end else begin
                                    o_cursor_col <= o_cursor_col + 4'd1;
                                end
                            end
                        end
                    end
                    ST_ESC: begin
                        if (o_byte_data == c_ascii_lbrk) begin
                            state <= ST_PARAM;
                            p0    <= 7'd0;
                            p1    <= 7'd0;
                            p_sel <= 1'b0;
                        end else begin
                            o_err_seq <= 1'b1;
                            state     <= ST_TEXT;
                        end
                    end
                    ST_PARAM: begin
                        if (o_byte_data >= 8'h30 && o_byte_data <= 8'h39) begin
                            if (p_sel) begin
                                p1 <= f_sat_param(p1, o_byte_data[3:0], c_max_par);
                            end else begin
                                p0 <= f_sat_param(p0, o_byte_data[3:0], c_max_par);
                            end
                        end else if (o_byte_data == c_ascii_semi) begin
                            p_sel <= 1'b1;
                        end else if (o_byte_data == c_ascii_j) begin
                            o_dat_ascii_line1   <= {16{c_ascii_space}};
                            o_dat_ascii_line2   <= {16{c_ascii_space}};
                            o_cursor_row        <= 1'b0;
                            o_cursor_col        <= 4'd0;
                            overflow            <= 1'b0;
                            o_evt_clear_display <= 1'b1;
                            state               <= ST_TEXT;
                        end else if (o_byte_data == c_ascii_h) begin
                            o_cursor_row     <= (p0 != 7'd0);
                            o_cursor_col     <= (p1 > 7'(c_last_col)) ? c_last_col : p1[3:0];
                            overflow         <= 1'b0;
                            o_evt_cursor_set <= 1'b1;
                            state            <= ST_TEXT;
                        end else begin
                            o_err_seq <= 1'b1;
                            state     <= ST_TEXT;
                        end
                    end
                    default: state <= ST_TEXT;
                endcase
            end
            if (csn_end) begin
                state <= ST_TEXT;
            end
        end
    end

endmodule

// File: tb/tb_pmod_cls_spi_responder.sv
// Self-checking bench for pmod_cls_spi_responder: table of command frames,
// corner-case sequences and random frames against a byte-stream model.
module tb_pmod_cls_spi_responder;
    import pmod_cls_spi_responder_pkg::*;

    localparam int SYNC = 2;

    logic i_clk_20mhz = 1'b0;
    logic i_rstn_20mhz = 1'b0;
    logic o_byte_valid, o_evt_clear_display, o_evt_cursor_set, o_cursor_row;
    logic o_err_frame, o_err_seq;
    logic [7:0] o_byte_data;
    logic [3:0] o_cursor_col;
    t_pmod_cls_ascii_line_16 o_dat_ascii_line1, o_dat_ascii_line2;

    pmod_cls_spi_responder_if spi();

    pmod_cls_spi_responder #(
        .parm_sync_stages (SYNC),
        .parm_line_len    (16),
        .parm_max_param   (99)
    ) dut (
        .i_clk_20mhz         (i_clk_20mhz),
        .i_rstn_20mhz        (i_rstn_20mhz),
        .spi                 (spi),
        .o_byte_valid        (o_byte_valid),
        .o_byte_data         (o_byte_data),
        .o_evt_clear_display (o_evt_clear_display),
        .o_evt_cursor_set    (o_evt_cursor_set),
        .o_cursor_row        (o_cursor_row),
        .o_cursor_col        (o_cursor_col),
        .o_dat_ascii_line1   (o_dat_ascii_line1),
        .o_dat_ascii_line2   (o_dat_ascii_line2),
        .o_err_frame         (o_err_frame),
        .o_err_seq           (o_err_seq)
    );

    // 20 MHz system clock
    always #25 i_clk_20mhz = ~i_clk_20mhz;

    int cyc = 0;
    int riseCyc = 0, validCyc = 0;
    int nValid = 0, nClr = 0, nCur = 0, nFrame = 0, nSeq = 0;
    int sValid, sClr, sCur, sFrame, sSeq;
    int nVec = 0, nMis = 0;

    // Cycle counter used to measure strobe latency
    always @(posedge i_clk_20mhz) cyc <= cyc + 1;

    // Count every high cycle of each pulse output
    always @(negedge i_clk_20mhz) begin
        if (o_byte_valid) begin
            nValid++;
            validCyc = cyc;
        end
        if (o_evt_clear_display) nClr++;
        if (o_evt_cursor_set) nCur++;
        if (o_err_frame) nFrame++;
        if (o_err_seq) nSeq++;
    end

    // ---------------- reference model ----------------
    logic [7:0] mLine [2][16];
    int  mRow, mCol;
    bit  mFull, mInEsc;
    logic [7:0] escBuf[$];
    int  eClr, eCur, eSeq;

    task automatic modelReset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 16; c++) mLine[r][c] = 8'h20;
        mRow = 0; mCol = 0; mFull = 0; mInEsc = 0;
        escBuf.delete();
    endtask

    task automatic modelByte(input logic [7:0] b);
        int p[2];
        int k;
        if (!mInEsc) begin
            if (b == 8'h1B) begin
                mInEsc = 1;
                escBuf.delete();
            end else if (b >= 8'h20 && b <= 8'h7E) begin
                if (mFull) eSeq++;
                else begin
                    mLine[mRow][mCol] = b;
                    if (mCol == 15) mFull = 1; else mCol++;
                end
            end
        end else if (escBuf.size() == 0) begin
            if (b == 8'h5B) escBuf.push_back(b);
            else begin
                eSeq++;
                mInEsc = 0;
            end
        end else if ((b >= 8'h30 && b <= 8'h39) || b == 8'h3B) begin
            escBuf.push_back(b);
        end else begin
            if (b == 8'h6A) begin
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 16; c++) mLine[r][c] = 8'h20;
                mRow = 0; mCol = 0; mFull = 0;
                eClr++;
            end else if (b == 8'h48) begin
                p[0] = 0; p[1] = 0; k = 0;
                for (int i = 1; i < escBuf.size(); i++) begin
                    if (escBuf[i] == 8'h3B) k = 1;
                    else begin
                        p[k] = p[k] * 10 + int'(escBuf[i] - 8'h30);
                        if (p[k] > 99) p[k] = 99;
                    end
                end
                mRow = (p[0] != 0) ? 1 : 0;
                mCol = (p[1] > 15) ? 15 : p[1];
                mFull = 0;
                eCur++;
            end else begin
                eSeq++;
            end
            mInEsc = 0;
        end
    endtask

    function automatic logic [127:0] modelLine(input int r);
        logic [127:0] v;
        for (int c = 0; c < 16; c++) v[c*8 +: 8] = mLine[r][c];
        return v;
    endfunction

    // ---------------- drivers / checkers ----------------
    logic [7:0] txq[$];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic halfBit();
        repeat (4) @(posedge i_clk_20mhz);
        #1;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi.ei_copi = b[7-i];
            halfBit();
            spi.ei_sck = 1'b1;
            riseCyc = cyc;
            halfBit();
            spi.ei_sck = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (12) @(posedge i_clk_20mhz);
        #1;
    endtask

    // Send txq as one CSN frame and feed the same bytes to the model
    task automatic applyStimulus();
        spi.ei_csn = 1'b0;
        halfBit();
        foreach (txq[k]) sendBits(txq[k], 8);
        halfBit();
        spi.ei_csn = 1'b1;
        settle();
        foreach (txq[k]) modelByte(txq[k]);
        mInEsc = 0;
    endtask

    task automatic snap();
        sValid = nValid; sClr = nClr; sCur = nCur; sFrame = nFrame; sSeq = nSeq;
        eClr = 0; eCur = 0; eSeq = 0;
    endtask

    task automatic checkModelState(input string tag);
        checkOutput({tag, ".row"}, 128'(o_cursor_row), 128'(mRow));
        checkOutput({tag, ".col"}, 128'(o_cursor_col), 128'(mCol));
        checkOutput({tag, ".line1"}, o_dat_ascii_line1, modelLine(0));
        checkOutput({tag, ".line2"}, o_dat_ascii_line2, modelLine(1));
    endtask

    typedef struct {
        logic [63:0] data;
        int len;
        int dClr;
        int dCur;
        int dSeq;
        int row;
        int col;
    } vec_t;

    vec_t vecs[15];

    logic [7:0] pick;
    int nb;

    initial begin
        spi.ei_sck = 1'b0;
        spi.ei_csn = 1'b1;
        spi.ei_copi = 1'b0;
        modelReset();

        vecs[0]  = '{64'h1B5B6A,           3, 1, 0, 0, 0, 0};
        vecs[1]  = '{64'h1B5B313B3348,     6, 0, 1, 0, 1, 3};
        vecs[2]  = '{64'h4869,             2, 0, 0, 0, 1, 5};
        vecs[3]  = '{64'h1B5B303B3048,     6, 0, 1, 0, 0, 0};
        vecs[4]  = '{64'h4141414141414141, 8, 0, 0, 0, 0, 8};
        vecs[5]  = '{64'h4141414141414141, 8, 0, 0, 0, 0, 15};
        vecs[6]  = '{64'h41,               1, 0, 0, 1, 0, 15};
        vecs[7]  = '{64'h1B5B353B393948,   7, 0, 1, 0, 1, 15};
        vecs[8]  = '{64'h1B5B3B3748,       5, 0, 1, 0, 0, 7};
        vecs[9]  = '{64'h1B5B323B333B3448, 8, 0, 1, 0, 1, 15};
        vecs[10] = '{64'h1B71,             2, 0, 0, 1, 1, 15};
        vecs[11] = '{64'h1B5B357A,         4, 0, 0, 1, 1, 15};
        vecs[12] = '{64'h0D07,             2, 0, 0, 0, 1, 15};
        vecs[13] = '{64'h5A,               1, 0, 0, 0, 1, 15};
        vecs[14] = '{64'h59,               1, 0, 0, 1, 1, 15};

        // Reset state
        repeat (5) @(posedge i_clk_20mhz);
        #1;
        checkOutput("rst.byte_data", 128'(o_byte_data), 128'h00);
        checkOutput("rst.pulses", 128'({o_byte_valid, o_evt_clear_display, o_evt_cursor_set, o_err_frame, o_err_seq}), 128'h0);
        checkOutput("rst.cipo", 128'({spi.eo_cipo_o, spi.eo_cipo_t}), 128'b01);
        checkModelState("rst");
        i_rstn_20mhz = 1'b1;
        repeat (3) @(posedge i_clk_20mhz);
        #1;

        // Single raw byte and strobe latency
        snap();
        txq = '{8'hA5};
        applyStimulus();
        checkOutput("a5.valid_cnt", 128'(nValid - sValid), 128'd1);
        checkOutput("a5.data", 128'(o_byte_data), 128'hA5);
        checkOutput("a5.errs", 128'((nFrame - sFrame) + (nSeq - sSeq)), 128'd0);
        checkOutput("a5.latency", 128'(validCyc - riseCyc), 128'(SYNC + 2));

        // Table of command/text frames
        for (int v = 0; v < 15; v++) begin
            snap();
            txq.delete();
            for (int i = 0; i < vecs[v].len; i++)
                txq.push_back(vecs[v].data[8*(vecs[v].len-1-i) +: 8]);
            applyStimulus();
            checkOutput($sformatf("vec%0d.valid", v), 128'(nValid - sValid), 128'(vecs[v].len));
            checkOutput($sformatf("vec%0d.clr", v), 128'(nClr - sClr), 128'(vecs[v].dClr));
            checkOutput($sformatf("vec%0d.cur", v), 128'(nCur - sCur), 128'(vecs[v].dCur));
            checkOutput($sformatf("vec%0d.seq", v), 128'(nSeq - sSeq), 128'(vecs[v].dSeq));
            checkOutput($sformatf("vec%0d.frame", v), 128'(nFrame - sFrame), 128'd0);
            checkOutput($sformatf("vec%0d.row", v), 128'(o_cursor_row), 128'(vecs[v].row));
            checkOutput($sformatf("vec%0d.col", v), 128'(o_cursor_col), 128'(vecs[v].col));
            checkModelState($sformatf("vec%0d", v));
        end

        // Partial byte then a full 'A'
        txq = '{8'h1B, 8'h5B, 8'h6A};
        applyStimulus();
        snap();
        spi.ei_csn = 1'b0;
        halfBit();
        sendBits(8'hFF, 5);
        halfBit();
        spi.ei_csn = 1'b1;
        settle();
        txq = '{8'h41};
        applyStimulus();
        checkOutput("frame.err_cnt", 128'(nFrame - sFrame), 128'd1);
        checkOutput("frame.valid", 128'(nValid - sValid), 128'd1);
        checkOutput("frame.data", 128'(o_byte_data), 128'h41);
        checkOutput("frame.char", 128'(o_dat_ascii_line1[0]), 128'h41);
        checkModelState("frame");

        // CSN rises on the same edge as the 8th SCK rise
        snap();
        spi.ei_csn = 1'b0;
        halfBit();
        sendBits(8'h51, 7);
        spi.ei_copi = 1'b1;
        halfBit();
        spi.ei_sck = 1'b1;
        spi.ei_csn = 1'b1;
        halfBit();
        spi.ei_sck = 1'b0;
        settle();
        modelByte(8'h51);
        mInEsc = 0;
        checkOutput("simul.valid", 128'(nValid - sValid), 128'd1);
        checkOutput("simul.frame", 128'(nFrame - sFrame), 128'd0);
        checkOutput("simul.data", 128'(o_byte_data), 128'h51);
        checkModelState("simul");

        // Random frames against the model
        for (int f = 0; f < 30; f++) begin
            snap();
            txq.delete();
            nb = $urandom_range(1, 8);
            for (int i = 0; i < nb; i++) begin
                case ($urandom_range(0, 9))
                    0: pick = 8'h1B;
                    1: pick = 8'h5B;
                    2, 3: pick = 8'(8'h30 + $urandom_range(0, 9));
                    4: pick = 8'h3B;
                    5: pick = 8'h6A;
                    6: pick = 8'h48;
                    7, 8: pick = 8'($urandom_range(32, 126));
                    default: pick = 8'($urandom_range(0, 255));
                endcase
                txq.push_back(pick);
            end
            applyStimulus();
            checkOutput($sformatf("rnd%0d.valid", f), 128'(nValid - sValid), 128'(nb));
            checkOutput($sformatf("rnd%0d.events", f),
                        128'({16'(nClr - sClr), 16'(nCur - sCur), 16'(nSeq - sSeq)}),
                        128'({16'(eClr), 16'(eCur), 16'(eSeq)}));
            checkModelState($sformatf("rnd%0d", f));
        end

        // Bad escape, then reset in the middle of a byte
        snap();
        txq = '{8'h1B, 8'h5B, 8'h78};
        applyStimulus();
        checkOutput("escx.seq", 128'(nSeq - sSeq), 128'd1);
        spi.ei_csn = 1'b0;
        halfBit();
        sendBits(8'hC3, 4);
        i_rstn_20mhz = 1'b0;
        #1;
        modelReset();
        snap();
        checkOutput("midrst.byte_data", 128'(o_byte_data), 128'h00);
        checkOutput("midrst.pulses", 128'({o_byte_valid, o_evt_clear_display, o_evt_cursor_set, o_err_frame, o_err_seq}), 128'h0);
        checkModelState("midrst");
        spi.ei_csn = 1'b1;
        spi.ei_sck = 1'b0;
        repeat (6) @(posedge i_clk_20mhz);
        #1;
        checkOutput("midrst.no_pulses",
                    128'((nValid - sValid) + (nClr - sClr) + (nCur - sCur) + (nFrame - sFrame) + (nSeq - sSeq)),
                    128'd0);
        i_rstn_20mhz = 1'b1;
        repeat (3) @(posedge i_clk_20mhz);
        #1;
        txq = '{8'h4B};
        applyStimulus();
        checkOutput("postrst.frame", 128'(nFrame - sFrame), 128'd0);
        checkModelState("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
